// File: rtl/tis_core.sv
// Single-node TIS-100-style core: one instruction per clock from a parent-supplied
// program, with a saturating signed accumulator, a backup register and a 7-seg decoder leaf.

module hex_to_7seg (
  input  logic [3:0] hexval,
  output logic [6:0] ledcode
);
  // Active-low segments, bit0 = a ... bit6 = g
  always_comb begin
    ledcode = 7'h7F;
    case (hexval)
      4'h0: ledcode = 7'h40;
      4'h1: ledcode = 7'h79;
      4'h2: ledcode = 7'h24;
      4'h3: ledcode = 7'h30;
      4'h4: ledcode = 7'h19;
      4'h5: ledcode = 7'h12;
      4'h6: ledcode = 7'h02;
      4'h7: ledcode = 7'h78;
      4'h8: ledcode = 7'h00;
      4'h9: ledcode = 7'h10;
      4'hA: ledcode = 7'h08;
      4'hB: ledcode = 7'h03;
      4'hC: ledcode = 7'h46;
      4'hD: ledcode = 7'h21;
      4'hE: ledcode = 7'h06;
      4'hF: ledcode = 7'h0E;
      default: ledcode = 7'h7F;
    endcase
  end
endmodule

module tis_core (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               pLength,
  input  logic [15:0]              prog [0:14],
  output logic [3:0]               pc,
  output logic signed [10:0]       acc,
  output logic signed [10:0]       bak
);
  localparam int DATA_W = 11;
  localparam int WIDE_W = 13;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_MOV = 4'h1, OP_SWP = 4'h2, OP_SAV = 4'h3,
    OP_ADD = 4'h4, OP_SUB = 4'h5, OP_NEG = 4'h6, OP_JMP = 4'h7,
    OP_JEZ = 4'h8, OP_JNZ = 4'h9, OP_JGZ = 4'hA, OP_JLZ = 4'hB,
    OP_JRO = 4'hC
  } opcode_t;

  function automatic logic signed [DATA_W-1:0] sat_acc(input logic signed [WIDE_W-1:0] v);
    if (v > 13'sd999)
      return 11'sd999;
    else if (v < -13'sd999)
      return -11'sd999;
    else
      return v[DATA_W-1:0];
  endfunction

  logic [3:0]               len;
  logic [15:0]              instr;
  logic [3:0]               opcode;
  logic signed [DATA_W-1:0] imm;
  logic signed [DATA_W-1:0] src;
  logic signed [WIDE_W-1:0] src_w;
  logic signed [WIDE_W-1:0] acc_w;
  logic signed [WIDE_W-1:0] jro_sum;
  logic signed [WIDE_W-1:0] len_w;
  logic [4:0]               pc_inc;
  logic [3:0]               pc_seq;
  logic [3:0]               tgt;
  logic [3:0]               pc_tgt;
  logic [3:0]               pc_jro;
  logic [3:0]               pc_nxt;
  logic signed [DATA_W-1:0] acc_nxt;
  logic signed [DATA_W-1:0] bak_nxt;

  // Fetch, decode and execute all resolve combinationally within the cycle
  always_comb begin
    len     = (pLength == 4'd0) ? 4'd1 : pLength;
    instr   = (pc < 4'd15) ? prog[pc] : 16'h0000;
    opcode  = instr[15:12];
    imm     = $signed(instr[10:0]);
    src     = instr[11] ? acc : imm;
    src_w   = {{(WIDE_W-DATA_W){src[DATA_W-1]}}, src};
    acc_w   = {{(WIDE_W-DATA_W){acc[DATA_W-1]}}, acc};
    len_w   = $signed({{(WIDE_W-4){1'b0}}, len});

    pc_inc  = {1'b0, pc} + 5'd1;
    pc_seq  = (pc_inc >= {1'b0, len}) ? 4'd0 : pc_inc[3:0];
    tgt     = instr[3:0];
    pc_tgt  = (tgt >= len) ? 4'd0 : tgt;

    // Relative jump lands inside [0, L-1] rather than wrapping
    jro_sum = $signed({{(WIDE_W-4){1'b0}}, pc}) + src_w;
    if (jro_sum < 13'sd0)
      pc_jro = 4'd0;
    else if (jro_sum > len_w - 13'sd1)
      pc_jro = len - 4'd1;
    else
      pc_jro = jro_sum[3:0];

    pc_nxt  = pc_seq;
    acc_nxt = acc;
    bak_nxt = bak;
    case (opcode)
      OP_MOV: acc_nxt = sat_acc(src_w);
      OP_SWP: begin
        acc_nxt = bak;
        bak_nxt = acc;
      end
      OP_SAV: bak_nxt = acc;
      OP_ADD: acc_nxt = sat_acc(acc_w + src_w);
      OP_SUB: acc_nxt = sat_acc(acc_w - src_w);
      OP_NEG: acc_nxt = sat_acc(-acc_w);
      OP_JMP: pc_nxt = pc_tgt;
      OP_JEZ: if (acc == 11'sd0) pc_nxt = pc_tgt;
      OP_JNZ: if (acc != 11'sd0) pc_nxt = pc_tgt;
      OP_JGZ: if (acc > 11'sd0)  pc_nxt = pc_tgt;
      OP_JLZ: if (acc < 11'sd0)  pc_nxt = pc_tgt;
      OP_JRO: pc_nxt = pc_jro;
      default: ;
    endcase

    // A program shortened under a running pc restarts from the top
    if (pc >= len)
      pc_nxt = 4'd0;
  end

  // Architectural state boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= 4'd0;
      acc <= '0;
      bak <= '0;
    end else begin
      pc  <= pc_nxt;
      acc <= acc_nxt;
      bak <= bak_nxt;
    end
  end
endmodule

// File: tb/tb_tis_core.sv
// Directed bench for tis_core and hex_to_7seg: hand-computed pc/acc/bak
// expectations after each clock edge, plus decoder code points.

module tb_tis_core;
  logic              clk;
  logic              rst;
  logic [3:0]        pLength;
  logic [15:0]       prog [0:14];
  logic [3:0]        pc;
  logic signed [10:0] acc;
  logic signed [10:0] bak;
  logic [3:0]        hexval;
  logic [6:0]        ledcode;

  int errors = 0;
  int checks = 0;

  tis_core dut (
    .clk     (clk),
    .rst     (rst),
    .pLength (pLength),
    .prog    (prog),
    .pc      (pc),
    .acc     (acc),
    .bak     (bak)
  );

  hex_to_7seg seg (
    .hexval  (hexval),
    .ledcode (ledcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [15:0] obs,
                       input logic signed [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] p0, input logic [15:0] p1,
                      input logic [15:0] p2, input logic [15:0] p3);
    for (int i = 0; i < 15; i++) prog[i] = 16'h0000;
    prog[0] = p0;
    prog[1] = p1;
    prog[2] = p2;
    prog[3] = p3;
  endtask

  task automatic restart(input logic [15:0] p0, input logic [15:0] p1,
                         input logic [15:0] p2, input logic [15:0] p3);
    rst = 1'b1;
    load(p0, p1, p2, p3);
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    pLength = 4'd4;
    hexval  = 4'd0;
    load(16'h4001, 16'h4001, 16'h4001, 16'h4001);

    // Reset
    step();
    check("rst_pc", pc, 0);
    check("rst_acc", acc, 0);
    check("rst_bak", bak, 0);
    step();
    check("rst_hold_pc", pc, 0);
    check("rst_hold_acc", acc, 0);

    // Loop wrap: ADD 1 x4
    rst = 1'b0;
    step();
    check("wrap_pc1", pc, 1);
    check("wrap_acc1", acc, 1);
    repeat (3) step();
    check("wrap_pc4", pc, 0);
    check("wrap_acc4", acc, 4);
    repeat (4) step();
    check("wrap_acc8", acc, 8);

    // Reset mid-program
    rst = 1'b1;
    step();
    check("midrst_pc", pc, 0);
    check("midrst_acc", acc, 0);
    rst = 1'b0;

    // Saturation: MOV 900, ADD 200, NEG, SUB 500
    restart(16'h1384, 16'h40C8, 16'h6000, 16'h51F4);
    step(); check("sat_mov", acc, 900);
    step(); check("sat_add", acc, 999);
    step(); check("sat_neg", acc, -999);
    step(); check("sat_sub", acc, -999);

    // MOV 1023 clamps to 999
    restart(16'h13FF, 16'h0000, 16'h0000, 16'h0000);
    step(); check("mov_1023", acc, 999);

    // SAV/SWP: MOV 5, SAV, MOV 7, SWP
    restart(16'h1005, 16'h3000, 16'h1007, 16'h2000);
    step(); step();
    check("sav_bak", bak, 5);
    step(); step();
    check("swp_acc", acc, 5);
    check("swp_bak", bak, 7);

    // Conditional jumps: MOV 0, JEZ 3, ADD 1, JGZ 0 -> pc 0,1,3,0,1,3
    restart(16'h1000, 16'h8003, 16'h4001, 16'hA000);
    step(); check("cj_pc_a", pc, 1);
    step(); check("cj_pc_b", pc, 3);
    step(); check("cj_pc_c", pc, 0);
    step(); check("cj_pc_d", pc, 1);
    step(); check("cj_pc_e", pc, 3);
    check("cj_acc", acc, 0);

    // JNZ/JLZ taken: MOV -3, JLZ 3, NOP, JNZ 1
    restart(16'h17FD, 16'hB003, 16'h0000, 16'h9001);
    step(); step(); check("jlz_pc", pc, 3);
    step(); check("jnz_pc", pc, 1);

    // JMP 9 beyond L=4 lands on 0
    restart(16'h0000, 16'h7009, 16'h0000, 16'h0000);
    step(); check("jmp_pre", pc, 1);
    step(); check("jmp_oob", pc, 0);

    // JRO -5 at pc=2 clamps to 0
    restart(16'h0000, 16'h0000, 16'hC7FB, 16'h0000);
    step(); step(); check("jro_neg_pre", pc, 2);
    step(); check("jro_neg", pc, 0);

    // MOV 20, JRO ACC -> clamps to 3, then JRO 0 stalls
    restart(16'h1014, 16'hC800, 16'h0000, 16'hC000);
    step(); check("jro_acc_mov", acc, 20);
    step(); check("jro_acc_pc", pc, 3);
    repeat (3) step();
    check("jro0_hold", pc, 3);

    // pLength lowered under a running pc
    pLength = 4'd2;
    step(); check("shrink_pc", pc, 0);

    // pLength 0 behaves as 1: ADD 1 repeats at pc 0
    pLength = 4'd0;
    restart(16'h4001, 16'h0000, 16'h0000, 16'h0000);
    step(); step();
    check("len0_pc", pc, 0);
    check("len0_acc", acc, 2);

    // Decoder
    hexval = 4'h0; #1; check("seg_0", ledcode, 16'h40);
    hexval = 4'h8; #1; check("seg_8", ledcode, 16'h00);
    hexval = 4'hA; #1; check("seg_A", ledcode, 16'h08);
    hexval = 4'hF; #1; check("seg_F", ledcode, 16'h0E);
    hexval = 4'h4; #1; check("seg_4", ledcode, 16'h19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
